// File: rtl/module_split_fields_pkg.sv
// Shared types and field layout for the split-fields word assembler.
package module_split_fields_pkg;

    typedef enum logic [1:0] {
        StHi   = 2'd0,
        StLo   = 2'd1,
        StFull = 2'd2
    } state_e;

    localparam int unsigned A_W    = 4;
    localparam int unsigned B_W    = 4;
    localparam int unsigned C_W    = 8;
    localparam int unsigned HI_W   = A_W + B_W;
    localparam int unsigned WORD_W = A_W + B_W + C_W;

    localparam int unsigned C_OFF = 0;
    localparam int unsigned B_OFF = C_OFF + C_W;
    localparam int unsigned A_OFF = B_OFF + B_W;

endpackage

// File: rtl/split_fields_sat_cnt.sv
// Saturating up-counter with increment enable; holds at all-ones instead of wrapping.
module split_fields_sat_cnt #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    output logic [Width-1:0] cnt_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {Width{1'b1}})) begin
            cnt_d = cnt_q + Width'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/module_split_fields.sv
// Assembles {high, low} byte pairs into a 16-bit word with an a/b/c field split.
// Define MODULE_SPLIT_FIELDS_ERRCNT_EN to build the saturating resync error counter.
module module_split_fields
    import module_split_fields_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        in_byte,
    input  logic              in_valid,
    input  logic              in_sof,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       out_concat,
    output logic [3:0]        out_a,
    output logic [3:0]        out_b,
    output logic [7:0]        out_c,
    output logic [CNT_W-1:0]  out_err_cnt
);

    state_e            state_q;
    logic [HI_W-1:0]   hi_q;
    logic [WORD_W-1:0] word_q;
    logic              valid_q;
    logic              accept;

    // Only the full state backpressures, and then only on the downstream handshake.
    assign in_ready = (state_q == StFull) ? out_ready : 1'b1;
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StHi;
            hi_q    <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                StHi: begin
                    if (accept) begin
                        hi_q    <= in_byte;
                        state_q <= StLo;
                    end
                end
                StLo: begin
                    if (accept) begin
                        if (in_sof) begin
                            hi_q <= in_byte;
                        end else begin
                            word_q  <= {hi_q, in_byte};
                            valid_q <= 1'b1;
                            state_q <= StFull;
                        end
                    end
                end
                StFull: begin
                    if (out_ready) begin
                        valid_q <= 1'b0;
                        if (in_valid) begin
                            hi_q    <= in_byte;
                            state_q <= StLo;
                        end else begin
                            state_q <= StHi;
                        end
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= StHi;
                end
            endcase
        end
    end

    assign out_valid  = valid_q;
    assign out_concat = word_q;
    assign out_a      = word_q[A_OFF +: A_W];
    assign out_b      = word_q[B_OFF +: B_W];
    assign out_c      = word_q[C_OFF +: C_W];

`ifdef MODULE_SPLIT_FIELDS_ERRCNT_EN
    logic resync;
    assign resync = accept & in_sof & (state_q == StLo);

    split_fields_sat_cnt #(
        .Width (CNT_W)
    ) u_err_cnt (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .inc_i  (resync),
        .cnt_o  (out_err_cnt)
    );
`else
    assign out_err_cnt = '0;
`endif

endmodule

// File: doc/module_split_fields.md
MODULE_SPLIT_FIELDS -- requirements
Module: module_split_fields

Interface
REQ-001 Parameter CNT_W, default 8, width of the resync error counter.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_byte  input  8  serial byte stream; a word is the high byte {a,b} followed by the low byte c.
REQ-005 in_valid  input  1  in_byte and in_sof are valid this cycle.
REQ-006 in_sof  input  1  marks the first (high) byte of a word.
REQ-007 in_ready  output  1  block accepts a byte this cycle.
REQ-008 out_valid  output  1  an assembled word is presented.
REQ-009 out_ready  input  1  downstream consumes the presented word.
REQ-010 out_concat  output  16  assembled word {high byte, low byte}.
REQ-011 out_a  output  4  out_concat[15:12].
REQ-012 out_b  output  4  out_concat[11:8].
REQ-013 out_c  output  8  out_concat[7:0].
REQ-014 out_err_cnt  output  CNT_W  saturating count of resync events.

Function
REQ-015 A byte SHALL be accepted on a clock edge where in_valid and in_ready are both high.
REQ-016 FSM SHALL have three states: S_HI (awaiting the high byte), S_LO (awaiting the low byte), and S_FULL (word held).
REQ-017 S_HI: in_ready=1; an accepted byte SHALL be stored as the high byte and the FSM SHALL go to S_LO, regardless of in_sof.
REQ-018 S_LO: in_ready=1; an accepted byte with in_sof=0 SHALL be stored as the low byte, and the FSM SHALL go to S_FULL.
REQ-019 S_LO: an accepted byte with in_sof=1 is a resync: it SHALL replace the high byte, the FSM SHALL stay in S_LO, and out_err_cnt SHALL increment.
REQ-020 S_FULL: out_valid=1 and in_ready=out_ready.
REQ-021 S_FULL with out_ready=1 and no byte accepted: the FSM SHALL go to S_HI.
REQ-022 S_FULL with out_ready=1 and a byte accepted: the byte SHALL become the new high byte and the FSM SHALL go to S_LO, giving zero-bubble handoff.
REQ-023 out_valid SHALL be 0 in S_HI and S_LO.
REQ-024 out_concat, out_a, out_b and out_c SHALL be registered values, stable while out_valid=1 and out_ready=0.
REQ-025 Latency SHALL be one cycle: out_valid rises on the edge after the low byte is accepted.
REQ-026 out_err_cnt SHALL saturate at 2^CNT_W-1 and SHALL never wrap.
REQ-027 out_valid SHALL never depend combinationally on in_valid.
REQ-028 in_ready may depend combinationally on out_ready only in S_FULL.

Reset
REQ-029 rst_n low SHALL immediately force state S_HI, with out_valid=0, in_ready=1, out_concat=0 and out_err_cnt=0.
REQ-030 Reset asserted mid-word SHALL discard any partial high byte.
REQ-031 Reset asserted in S_FULL SHALL discard the held word.
REQ-032 The first edge after rst_n deasserts SHALL be able to accept a high byte.

Configuration
REQ-033 Macro MODULE_SPLIT_FIELDS_ERRCNT_EN defined: out_err_cnt SHALL behave per REQ-019 and REQ-026.
REQ-034 Macro not defined: out_err_cnt SHALL be constant 0 and no counter flops SHALL exist; resync (REQ-019) SHALL still occur.

Structure
REQ-035 A shared package SHALL hold the FSM state enum, the field widths (A_W=4, B_W=4, C_W=8) and the field offset constants.
REQ-036 One sub-module, split_fields_sat_cnt (saturating counter with an increment enable), SHALL implement out_err_cnt.

Verification
REQ-037 Stream A5(sof) then 3C with out_ready=1 -> one cycle later out_valid=1, out_concat=A53C, out_a=A, out_b=5, out_c=3C.
REQ-038 Word 12/34 held with out_ready=0 for 5 cycles -> outputs stable at 1234 and in_ready=0; then out_ready=1 with 56(sof) accepted the same cycle -> FSM in S_LO, no bubble.
REQ-039 Bytes 11(sof), 22(sof), 33 -> out_concat=2233 and out_err_cnt=1 (0 without the macro).
REQ-040 CNT_W=2 with 5 resyncs -> out_err_cnt=3, saturated.
REQ-041 rst_n pulsed low after the high byte 7F -> outputs zero; then AB(sof), CD -> out_concat=ABCD.
REQ-042 in_valid toggled randomly between the high and low bytes -> only valid bytes are accepted, and words are assembled correctly.
